cut_sweep_controller: RTL and testbench

- Sequencer that exhaustively drives every input vector into two combinational circuits-under-test (CUT A, CUT B) sharing the same input bus, e.g. an original netlist and its balanced re-synthesis.
- Waits a programmable settle time per vector, then compresses CUT A outputs into a MISR signature and compares A against B bit-for-bit.
- Sits between the bench/host (start/abort/done handshake) and the CUT instances; the CUTs themselves are unclocked.

---
 rtl/cut_sweep_controller.sv | 145 ++++++++++++++
 tb/tb_cut_sweep_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_sweep_controller.sv
// cut_sweep_controller
// Walks every input vector through two unclocked circuits-under-test that share
// one input bus. For each vector it holds cut_x for a programmable settle time,
// then compresses CUT A's response into a MISR and compares A against B.
//
// Handshake: start is a level sampled only in IDLE. abort wins over start and
// ends a sweep early without a done pulse. done is a single-cycle pulse after the
// last vector. busy is high for the whole sweep. All outputs come from flops.
module cut_sweep_controller #(
  parameter int              N_IN   = 11,
  parameter int              N_OUT  = 18,
  parameter int              SETTLE = 1,
  parameter logic [N_OUT-1:0] POLY  = 18'h00081
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   cut_x,
  input  logic [N_OUT-1:0]  cut_f_a,
  input  logic [N_OUT-1:0]  cut_f_b,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  sig,
  output logic              mismatch,
  output logic [N_IN-1:0]   first_fail,
  output logic [N_IN:0]     fail_count
);

  // The counter only has to hold SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] X_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   FC_ONE   = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // state_q is kept as a plainly named register so checkers can bind to it.
  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt;

  // Control strobes decoded from the current state.
  logic            start_sweep;
  logic            capture_en;
  logic            step_x;
  logic            cnt_dec;

  // Next-state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; abort beats every other transition.
  always_comb begin
    state_d     = state_q;
    start_sweep = 1'b0;
    capture_en  = 1'b0;
    step_x      = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          start_sweep = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort)              state_d = ST_IDLE;
        else if (cnt == '0)     state_d = ST_CAPTURE;
        else                    cnt_dec = 1'b1;
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          capture_en = 1'b1;
          if (cut_x == '1) begin
            state_d = ST_DONE;
          end else begin
            step_x  = 1'b1;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: vector walk, settle counter, MISR and A/B compare results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cut_x      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sig        <= '0;
      mismatch   <= 1'b0;
      first_fail <= '0;
      fail_count <= '0;
    end else begin
      // Status flags follow the state being entered so they line up with it.
      busy <= (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
      done <= (state_d == ST_DONE);

      if (start_sweep) begin
        cut_x      <= '0;
        cnt        <= CNT_LOAD;
        sig        <= '0;
        mismatch   <= 1'b0;
        first_fail <= '0;
        fail_count <= '0;
      end

      if (cnt_dec) cnt <= cnt - CNT_ONE;

      if (capture_en) begin
        sig <= {sig[N_OUT-2:0], 1'b0} ^ (sig[N_OUT-1] ? POLY : '0) ^ cut_f_a;
        if (cut_f_a != cut_f_b) begin
          fail_count <= fail_count + FC_ONE;
          if (!mismatch) first_fail <= cut_x;
          mismatch <= 1'b1;
        end
      end

      if (step_x) begin
        cut_x <= cut_x + X_ONE;
        cnt   <= CNT_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_cut_sweep_controller.sv
// Testbench for cut_sweep_controller: three instances (small, slow-settle,
// default-size) run one after another from a single directed sequence. CUT
// responses come from tables; expected results come from a vector-by-vector
// reference loop over those tables.
module tb_cut_sweep_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CUT response tables shared by the small and full instances (never run together).
  logic [63:0] tbl_a [0:2047];
  logic [63:0] tbl_b [0:2047];

  // ---------------- small instance: N_IN=2, N_OUT=4, SETTLE=1 ----------------
  logic       s_start = 1'b0, s_abort = 1'b0;
  logic [1:0] s_x, s_ff;
  logic [3:0] s_fa, s_fb, s_sig;
  logic [2:0] s_fc;
  logic       s_busy, s_done, s_mis;
  assign s_fa = tbl_a[{9'd0, s_x}][3:0];
  assign s_fb = tbl_b[{9'd0, s_x}][3:0];

  cut_sweep_controller #(.N_IN(2), .N_OUT(4), .SETTLE(1), .POLY(4'h3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .cut_x(s_x),
    .cut_f_a(s_fa), .cut_f_b(s_fb), .busy(s_busy), .done(s_done), .sig(s_sig),
    .mismatch(s_mis), .first_fail(s_ff), .fail_count(s_fc)
  );

  // ---------------- slow instance: N_IN=2, N_OUT=4, SETTLE=3 ----------------
  logic       w_start = 1'b0, w_abort = 1'b0;
  logic [1:0] w_x, w_ff;
  logic [3:0] w_fa, w_sig, w_mask = 4'h0;
  logic [2:0] w_fc;
  logic       w_busy, w_done, w_mis;
  assign w_fa = {2'b00, w_x} ^ w_mask;

  cut_sweep_controller #(.N_IN(2), .N_OUT(4), .SETTLE(3), .POLY(4'h3)) u_slow (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .cut_x(w_x),
    .cut_f_a(w_fa), .cut_f_b(w_fa), .busy(w_busy), .done(w_done), .sig(w_sig),
    .mismatch(w_mis), .first_fail(w_ff), .fail_count(w_fc)
  );

  // ---------------- full instance: defaults ----------------
  logic        f_start = 1'b0, f_abort = 1'b0;
  logic [10:0] f_x, f_ff;
  logic [17:0] f_fa, f_fb, f_sig;
  logic [11:0] f_fc;
  logic        f_busy, f_done, f_mis;
  assign f_fa = tbl_a[f_x][17:0];
  assign f_fb = tbl_b[f_x][17:0];

  cut_sweep_controller u_full (
    .clk(clk), .rst(rst), .start(f_start), .abort(f_abort), .cut_x(f_x),
    .cut_f_a(f_fa), .cut_f_b(f_fb), .busy(f_busy), .done(f_done), .sig(f_sig),
    .mismatch(f_mis), .first_fail(f_ff), .fail_count(f_fc)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One MISR step of width w.
  function automatic logic [63:0] misr(input logic [63:0] s, input logic [63:0] a,
                                       input logic [63:0] poly, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    misr = ((s << 1) & m) ^ (s[w-1] ? poly : 64'd0) ^ (a & m);
  endfunction

  // Reference: walk the first n vectors in order and accumulate the results.
  task automatic model(input int n, input int w, input logic [63:0] poly,
                       output logic [63:0] e_sig, output logic [63:0] e_ff,
                       output logic [63:0] e_fc, output logic [63:0] e_mis);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    e_sig = 0; e_ff = 0; e_fc = 0; e_mis = 0;
    for (int i = 0; i < n; i++) begin
      e_sig = misr(e_sig, tbl_a[i], poly, w);
      if ((tbl_a[i] & m) != (tbl_b[i] & m)) begin
        if (e_mis == 0) e_ff = 64'(i);
        e_mis = 1;
        e_fc++;
      end
    end
  endtask

  // Fill tables: identity or random A responses, B = A with nflt random bit flips.
  task automatic fill(input int n, input int w, input bit rnd, input int nflt);
    logic [63:0] m;
    int idx;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 2048; i++) begin
      if (i < n) tbl_a[i] = rnd ? ({$urandom, $urandom} & m) : 64'(i);
      else       tbl_a[i] = 64'd0;
      tbl_b[i] = tbl_a[i];
    end
    for (int k = 0; k < nflt; k++) begin
      idx = $urandom_range(n - 1, 0);
      tbl_b[idx] = tbl_b[idx] ^ (64'd1 << $urandom_range(w - 1, 0));
    end
  endtask

  // Small sweep: start sampled at the first edge (cycle 1 follows it). Checks
  // the cut_x walk and busy each cycle, optionally re-pulses start mid-sweep.
  task automatic small_sweep(input int restart_cyc, output int done_cyc);
    int cyc;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    while (cyc <= 20) begin
      if (s_done) begin
        done_cyc = cyc;
        chk("small_busy_at_done", 64'(s_busy), 64'd0);
        break;
      end
      if (cyc <= 8) begin
        chk("small_x_walk", 64'(s_x), 64'((cyc - 1) / 2));
        chk("small_busy", 64'(s_busy), 64'd1);
      end
      s_start = (cyc == restart_cyc);
      tick();
      cyc++;
    end
    s_start = 1'b0;
  endtask

  task automatic full_sweep(output int done_cyc);
    int cyc;
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    while (cyc <= 5000) begin
      if (f_done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] e_sig, e_ff, e_fc, e_mis;
  int dc;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      tbl_a[i] = 64'd0;
      tbl_b[i] = 64'd0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values.
    chk("rst_x", 64'(s_x), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_sig", 64'(s_sig), 64'd0);
    chk("rst_mis", 64'(s_mis), 64'd0);
    chk("rst_ff", 64'(s_ff), 64'd0);
    chk("rst_fc", 64'(s_fc), 64'd0);
    chk("rst_full_sig", 64'(f_sig), 64'd0);

    // Small sweep with identity responses.
    fill(4, 4, 1'b0, 0);
    small_sweep(0, dc);
    chk("small_done_cycle", 64'(dc), 64'd9);
    chk("small_sig", 64'(s_sig), 64'h3);
    chk("small_mis", 64'(s_mis), 64'd0);
    chk("small_fc", 64'(s_fc), 64'd0);
    tick();
    chk("small_done_one_cycle", 64'(s_done), 64'd0);

    // Fault injection at vectors 2 and 3, plus a start pulse while busy.
    fill(4, 4, 1'b0, 0);
    tbl_b[2] = tbl_b[2] ^ 64'd1;
    tbl_b[3] = tbl_b[3] ^ 64'd1;
    small_sweep(3, dc);
    chk("fault_done_cycle", 64'(dc), 64'd9);
    chk("fault_mis", 64'(s_mis), 64'd1);
    chk("fault_ff", 64'(s_ff), 64'd2);
    chk("fault_fc", 64'(s_fc), 64'd2);
    chk("fault_sig", 64'(s_sig), 64'h3);
    tick();

    // Random responses and faults on the small instance.
    for (int r = 0; r < 6; r++) begin
      fill(4, 4, 1'b1, $urandom_range(3, 0));
      model(4, 4, 64'h3, e_sig, e_ff, e_fc, e_mis);
      small_sweep(0, dc);
      chk("rnd_done_cycle", 64'(dc), 64'd9);
      chk("rnd_sig", 64'(s_sig), e_sig);
      chk("rnd_mis", 64'(s_mis), e_mis);
      chk("rnd_ff", 64'(s_ff), e_ff);
      chk("rnd_fc", 64'(s_fc), e_fc);
      tick();
    end

    // Settle timing: glitch in cycle 6 (x=1) is ignored, change held over
    // cycles 11-12 (x=2) is captured.
    fill(4, 4, 1'b0, 0);
    tbl_a[2] = tbl_a[2] ^ 64'h8;
    tbl_b[2] = tbl_a[2];
    model(4, 4, 64'h3, e_sig, e_ff, e_fc, e_mis);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    begin
      int cyc;
      cyc = 1;
      dc = -1;
      while (cyc <= 30) begin
        if (w_done) begin
          dc = cyc;
          break;
        end
        if (cyc <= 16) chk("slow_x_hold", 64'(w_x), 64'((cyc - 1) / 4));
        if (cyc == 6)                    w_mask = 4'h4;
        else if (cyc == 11 || cyc == 12) w_mask = 4'h8;
        else                             w_mask = 4'h0;
        tick();
        cyc++;
      end
      w_mask = 4'h0;
    end
    chk("slow_done_cycle", 64'(dc), 64'd17);
    chk("slow_sig", 64'(w_sig), e_sig);
    chk("slow_busy_at_done", 64'(w_busy), 64'd0);
    tick();

    // Abort in the CAPTURE cycle of vector 1.
    fill(4, 4, 1'b1, 0);
    tbl_b[0] = tbl_b[0] ^ 64'd1;
    tbl_b[1] = tbl_b[1] ^ 64'd2;
    model(1, 4, 64'h3, e_sig, e_ff, e_fc, e_mis);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (3) tick();           // now in cycle 4
    s_abort = 1'b1;
    tick();                      // cycle 5
    s_abort = 1'b0;
    chk("abort_busy", 64'(s_busy), 64'd0);
    chk("abort_x_hold", 64'(s_x), 64'd1);
    chk("abort_sig", 64'(s_sig), e_sig);
    chk("abort_fc", 64'(s_fc), e_fc);
    chk("abort_ff", 64'(s_ff), e_ff);
    chk("abort_mis", 64'(s_mis), e_mis);
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_done", 64'(s_done), 64'd0);
      tick();
    end

    // start and abort together in IDLE: no sweep.
    s_start = 1'b1;
    s_abort = 1'b1;
    tick();
    s_start = 1'b0;
    s_abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("prio_busy", 64'(s_busy), 64'd0);
      chk("prio_x", 64'(s_x), 64'd1);
      chk("prio_done", 64'(s_done), 64'd0);
      tick();
    end
    chk("prio_sig_hold", 64'(s_sig), e_sig);

    // Reset in the middle of a sweep that has already recorded a mismatch.
    fill(4, 4, 1'b1, 0);
    tbl_b[0] = tbl_b[0] ^ 64'd4;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (5) tick();           // cycle 6
    chk("pre_rst_mis", 64'(s_mis), 64'd1);
    rst = 1'b1;
    tick();                      // cycle 7
    rst = 1'b0;
    chk("mid_rst_x", 64'(s_x), 64'd0);
    chk("mid_rst_busy", 64'(s_busy), 64'd0);
    chk("mid_rst_done", 64'(s_done), 64'd0);
    chk("mid_rst_sig", 64'(s_sig), 64'd0);
    chk("mid_rst_mis", 64'(s_mis), 64'd0);
    chk("mid_rst_ff", 64'(s_ff), 64'd0);
    chk("mid_rst_fc", 64'(s_fc), 64'd0);
    tick();
    chk("mid_rst_no_done", 64'(s_done), 64'd0);
    fill(4, 4, 1'b0, 0);
    small_sweep(0, dc);
    chk("after_rst_done_cycle", 64'(dc), 64'd9);
    chk("after_rst_sig", 64'(s_sig), 64'h3);
    tick();

    // Full default-size sweep, random responses, no faults.
    fill(2048, 18, 1'b1, 0);
    model(2048, 18, 64'h00081, e_sig, e_ff, e_fc, e_mis);
    full_sweep(dc);
    chk("full_done_cycle", 64'(dc), 64'd4097);
    chk("full_sig", 64'(f_sig), e_sig);
    chk("full_fc", 64'(f_fc), 64'd0);
    chk("full_mis", 64'(f_mis), 64'd0);
    chk("full_x_end", 64'(f_x), 64'h7ff);
    tick();

    // Full sweep with a few random faults.
    fill(2048, 18, 1'b1, 4);
    model(2048, 18, 64'h00081, e_sig, e_ff, e_fc, e_mis);
    full_sweep(dc);
    chk("fullf_done_cycle", 64'(dc), 64'd4097);
    chk("fullf_sig", 64'(f_sig), e_sig);
    chk("fullf_fc", 64'(f_fc), e_fc);
    chk("fullf_ff", 64'(f_ff), e_ff);
    chk("fullf_mis", 64'(f_mis), e_mis);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
